// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the receive-side decoder.
// Segment order is {a,b,c,d,e,f,g}, active-low (0 = lit).
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic {
        WAIT_STABLE = 1'b0,
        LOCKED      = 1'b1
    } rx_state_e;

    localparam seg7_t SEG7_BLANK = 7'b1111111;

    localparam seg7_t SEG7_GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex-to-segment encoder.
// The legal flag marks the 16 hex glyphs, and blank marks the all-unlit pattern.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  seg7_t       seg,
    output logic        legal,
    output logic        blank,
    output logic [3:0]  value
);

    always_comb begin
        legal = 1'b0;
        value = '0;
        blank = (seg == SEG7_BLANK);
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == SEG7_GLYPH[i]) begin
                legal = 1'b1;
                value = i[3:0];
            end
        end
    end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Snoops a two-digit multiplexed 7-segment bus and recovers the hex value on each digit.
// Each pattern is accepted once, after it has been stable for STABLE_CYCLES synchronized cycles.
module seg7_rx_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic        dig_sel_in,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [1:0]  present,
    output logic        digit_valid,
    output logic        digit_err,
    output logic        digit_idx,
    output logic [3:0]  digit_val
);

    // The accept fires on the cycle that completes the run, so compare against STABLE_CYCLES-2.
    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 2);

    logic [1:0]  rst_pipe;
    logic        run;
    logic [7:0]  sync_q [SYNC_STAGES];
    logic [7:0]  samp;
    logic [7:0]  samp_q;
    logic        chg;
    rx_state_e   state, state_d;
    logic [15:0] cnt, cnt_d;
    logic        accept;
    logic        g_legal, g_blank;
    logic [3:0]  g_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign run = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            samp_q <= '1;
        end else if (run) begin
            sync_q[0] <= {dig_sel_in, seg_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            samp_q <= samp;
        end
    end

    assign samp = sync_q[SYNC_STAGES-1];
    assign chg  = (samp != samp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_STABLE;
            cnt   <= '0;
        end else if (run) begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            WAIT_STABLE: begin
                if (chg)                  cnt_d   = '0;
                else if (cnt == CNT_LAST) state_d = LOCKED;
                else                      cnt_d   = cnt + 16'd1;
            end
            LOCKED: begin
                if (chg) begin
                    state_d = WAIT_STABLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        accept = (state == WAIT_STABLE) && !chg && (cnt == CNT_LAST);
    end

    seg7_glyph_decode u_decode (
        .seg   (samp[6:0]),
        .legal (g_legal),
        .blank (g_blank),
        .value (g_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit0      <= '0;
            digit1      <= '0;
            present     <= '0;
            digit_valid <= 1'b0;
            digit_err   <= 1'b0;
            digit_idx   <= 1'b0;
            digit_val   <= '0;
        end else if (run) begin
            digit_valid <= 1'b0;
            digit_err   <= 1'b0;
            if (accept) begin
                if (g_legal) begin
                    digit_valid      <= 1'b1;
                    digit_val        <= g_value;
                    digit_idx        <= samp[7];
                    present[samp[7]] <= 1'b1;
                    if (samp[7]) digit1 <= g_value;
                    else         digit0 <= g_value;
                end else if (g_blank) begin
                    present[samp[7]] <= 1'b0;
                end else begin
                    digit_err        <= 1'b1;
                    digit_val        <= '0;
                    digit_idx        <= samp[7];
                    present[samp[7]] <= 1'b0;
                end
            end
        end
    end

endmodule
